videocard_loader: RTL and testbench

VIDEOCARD_LOADER -- requirements
Module: videocard_loader

---
 rtl/videocard_loader.sv | 218 +++++++++++++++++++++
 tb/tb_videocard_loader.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/videocard_loader.sv
// Command-driven loader for a card memory port and a control port.
// Optional poll timeout: define LOADER_TIMEOUT_EN.
module videocard_loader #(
  parameter int WIDTH        = 32,
  parameter int ADDR_W       = 17,
  parameter int READ_LATENCY = 2,
  parameter int POLL_GAP     = 4,
  parameter int TIMEOUT      = 65535
) (
  input  logic              clk,
  input  logic              reset_sink_reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [WIDTH-1:0]  cmd_data,
  output logic              rsp_valid,
  output logic [WIDTH-1:0]  rsp_data,
  output logic [ADDR_W-1:0] m_address,
  output logic [WIDTH-1:0]  m_writedata,
  input  logic [WIDTH-1:0]  m_readdata,
  output logic              m_write,
  output logic              m_read,
  output logic [3:0]        m_byteenable,
  output logic [2:0]        c_address,
  output logic [WIDTH-1:0]  c_writedata,
  input  logic [WIDTH-1:0]  c_readdata,
  output logic              c_write,
  output logic              c_read,
  output logic              busy,
  output logic              error
);

  localparam int CNT_W = 16;

`ifdef LOADER_TIMEOUT_EN
  localparam logic TMO_EN = 1'b1;
`else
  localparam logic TMO_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_MWR,
    S_MRD,
    S_CWR,
    S_POLL,
    S_GAP,
    S_CLEAR
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_polls;
  logic [ADDR_W-1:0]  r_m_addr;
  logic [WIDTH-1:0]   r_m_wdata;
  logic [2:0]         r_c_addr;
  logic [WIDTH-1:0]   r_c_wdata;
  logic [WIDTH-1:0]   r_sample;
  logic [WIDTH-1:0]   r_rsp_data;
  logic               r_rsp_valid;
  logic               r_error;
  logic               w_accept;
  logic               w_lat_done;
  logic               w_gap_done;
  logic               w_tmo;

  assign w_accept   = cmd_valid && (r_state == S_IDLE);
  assign w_lat_done = (r_cnt == CNT_W'(READ_LATENCY));
  assign w_gap_done = (r_cnt >= CNT_W'(POLL_GAP));
  assign w_tmo      = TMO_EN &&
                      (r_polls >= 32'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (reset_sink_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    cmd_ready = 1'b0;
    m_write   = 1'b0;
    m_read    = 1'b0;
    c_write   = 1'b0;
    c_read    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          unique case (cmd_op)
            2'b00:   w_next = S_MWR;
            2'b01:   w_next = S_MRD;
            2'b10:   w_next = S_CWR;
            default: w_next = S_POLL;
          endcase
        end
      end
      S_MWR: begin
        m_write = 1'b1;
        w_next  = S_IDLE;
      end
      S_MRD: begin
        m_read = (r_cnt == '0);
        if (w_lat_done) begin
          w_next = S_IDLE;
        end
      end
      S_CWR: begin
        c_write = 1'b1;
        w_next  = S_IDLE;
      end
      S_POLL: begin
        c_read = (r_cnt == '0);
        if (w_lat_done) begin
          if (c_readdata[0]) begin
            w_next = S_CLEAR;
          end else if (w_tmo) begin
            w_next = S_IDLE;
          end else begin
            w_next = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (w_gap_done) begin
          w_next = S_POLL;
        end
      end
      S_CLEAR: begin
        c_write = 1'b1;
        w_next  = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Latency/gap counter restarts on every state change; GAP counts from 1.
  always_ff @(posedge clk) begin
    if (reset_sink_reset) begin
      r_cnt <= '0;
    end else if (w_next != r_state) begin
      r_cnt <= (w_next == S_GAP) ? CNT_W'(1) : '0;
    end else if (r_state == S_MRD ||
                 r_state == S_POLL ||
                 r_state == S_GAP) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset_sink_reset) begin
      r_polls     <= '0;
      r_m_addr    <= '0;
      r_m_wdata   <= '0;
      r_c_addr    <= '0;
      r_c_wdata   <= '0;
      r_sample    <= '0;
      r_rsp_data  <= '0;
      r_rsp_valid <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      if (w_accept) begin
        unique case (cmd_op)
          2'b00: begin
            r_m_addr  <= cmd_addr;
            r_m_wdata <= cmd_data;
          end
          2'b01: begin
            r_m_addr <= cmd_addr;
          end
          2'b10: begin
            r_c_addr  <= cmd_addr[2:0];
            r_c_wdata <= cmd_data;
          end
          default: begin
            r_c_addr <= 3'd1;
            r_polls  <= '0;
          end
        endcase
      end
      if (r_state == S_MRD && w_lat_done) begin
        r_rsp_valid <= 1'b1;
        r_rsp_data  <= m_readdata;
      end
      if (r_state == S_POLL && w_lat_done) begin
        r_polls <= r_polls + 32'd1;
        if (c_readdata[0]) begin
          r_sample  <= c_readdata;
          r_c_wdata <= '0;
        end else if (w_tmo) begin
          r_rsp_valid <= 1'b1;
          r_rsp_data  <= '1;
          r_error     <= 1'b1;
        end
      end
      if (r_state == S_CLEAR) begin
        r_rsp_valid <= 1'b1;
        r_rsp_data  <= r_sample;
      end
    end
  end

  assign m_address    = r_m_addr;
  assign m_writedata  = r_m_wdata;
  assign m_byteenable = 4'b1111;
  assign c_address    = r_c_addr;
  assign c_writedata  = r_c_wdata;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_data     = r_rsp_data;
  assign busy         = (r_state != S_IDLE);
  assign error        = r_error & TMO_EN;

endmodule

// File: tb/tb_videocard_loader.sv
// Randomized self-checking bench for videocard_loader.
// Timeout scenario follows LOADER_TIMEOUT_EN.
module tb_videocard_loader;
  localparam int W   = 32;
  localparam int AW  = 17;
  localparam int RL  = 2;
  localparam int PG  = 4;
  localparam int TMO = 50;
  localparam int NEVER = 32'h7fff_ffff;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = '0;
  logic [AW-1:0] cmd_addr = '0;
  logic [W-1:0]  cmd_data = '0;
  logic          rsp_valid;
  logic [W-1:0]  rsp_data;
  logic [AW-1:0] m_address;
  logic [W-1:0]  m_writedata, m_readdata;
  logic          m_write, m_read;
  logic [3:0]    m_byteenable;
  logic [2:0]    c_address;
  logic [W-1:0]  c_writedata, c_readdata;
  logic          c_write, c_read, busy, error;

  videocard_loader #(
    .WIDTH(W), .ADDR_W(AW), .READ_LATENCY(RL),
    .POLL_GAP(PG), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset_sink_reset(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .m_address(m_address), .m_writedata(m_writedata),
    .m_readdata(m_readdata), .m_write(m_write),
    .m_read(m_read), .m_byteenable(m_byteenable),
    .c_address(c_address), .c_writedata(c_writedata),
    .c_readdata(c_readdata), .c_write(c_write),
    .c_read(c_read), .busy(busy), .error(error)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Card models: memory and control block, RL-cycle read pipes.
  logic [31:0] mem [int];
  logic [31:0] mpipe [RL];
  logic [31:0] cpipe [RL];
  logic [31:0] ctl [8];
  int fin_at = NEVER;
  int clr_cyc = -1;
  logic fin;
  assign fin = (cyc >= fin_at) && !(clr_cyc >= fin_at);
  assign m_readdata = mpipe[RL-1];
  assign c_readdata = cpipe[RL-1];

  always @(posedge clk) begin
    if (m_write) mem[int'(m_address)] = m_writedata;
    if (m_read && mem.exists(int'(m_address)))
      mpipe[0] <= mem[int'(m_address)];
    else
      mpipe[0] <= 32'h0;
    for (int i = 1; i < RL; i++) mpipe[i] <= mpipe[i-1];
    if (c_write) begin
      ctl[c_address] <= c_writedata;
      if (c_address == 3'd1 && !c_writedata[0])
        clr_cyc <= cyc;
    end
    if (!c_read)
      cpipe[0] <= 32'h0;
    else if (c_address == 3'd1)
      cpipe[0] <= {16'hA5A5, 15'h0, fin};
    else
      cpipe[0] <= ctl[c_address];
    for (int i = 1; i < RL; i++) cpipe[i] <= cpipe[i-1];
  end

  // Output monitor, sampled mid-cycle.
  int n_mw = 0, n_mr = 0, n_cw = 0, n_rsp = 0;
  int n_multi = 0, n_badcr = 0;
  logic [31:0] mw_a, mw_d, cw_a, cw_d, rsp_d;
  logic [3:0] mw_be;
  int mw_c, cw_c, rsp_c;
  int cr_q[$];
  logic [31:0] rsp_q[$];

  always @(negedge clk) begin
    if (int'(m_write) + int'(m_read) +
        int'(c_write) + int'(c_read) > 1) n_multi++;
    if (m_write) begin
      n_mw++; mw_a = 32'(m_address);
      mw_d = m_writedata; mw_be = m_byteenable; mw_c = cyc;
    end
    if (m_read) n_mr++;
    if (c_write) begin
      n_cw++; cw_a = 32'(c_address);
      cw_d = c_writedata; cw_c = cyc;
    end
    if (c_read) begin
      cr_q.push_back(cyc);
      if (c_address !== 3'd1) n_badcr++;
    end
    if (rsp_valid) begin
      n_rsp++; rsp_d = rsp_data; rsp_c = cyc;
      rsp_q.push_back(rsp_data);
    end
  end

  int n_cmp = 0, n_fail = 0;
  logic [31:0] exp_mem [int];

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic send(input logic [1:0] op,
                      input logic [AW-1:0] a,
                      input logic [W-1:0] d,
                      input bit hold, output int acc);
    int t = 0;
    bit r;
    cmd_op = op; cmd_addr = a; cmd_data = d;
    cmd_valid = 1'b1;
    do begin
      r = cmd_ready; acc = cyc + 1; tick(); t++;
    end while (!r && t < 2000);
    n_cmp++;
    if (!r) begin
      n_fail++;
      $display("FAIL accept_bound: no cmd_ready in %0d cycles", t);
    end
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int base, input int lim);
    int t = 0;
    while (n_rsp <= base && t < lim) begin tick(); t++; end
    n_cmp++;
    if (n_rsp <= base) begin
      n_fail++;
      $display("FAIL rsp_bound: no rsp_valid in %0d cycles", lim);
    end
  endtask

  task automatic test_reset();
    logic [7:0] got;
    rst = 1'b1; cmd_valid = 1'b0;
    repeat (3) tick();
    got = {m_write, m_read, c_write, c_read,
           rsp_valid, busy, error, cmd_ready};
    n_cmp++;
    if (got !== 8'b0000_0001) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b want 00000001", got);
    end
    n_cmp++;
    if ({m_address, m_writedata, c_address,
         c_writedata, rsp_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: addr/data outputs not zero");
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset: busy=%b ready=%b want 0 1",
               busy, cmd_ready);
    end
  endtask

  task automatic test_mem_write_boundary();
    int acc, b = n_mw;
    send(2'b00, 17'h10000, 32'h214C62A4, 1'b0, acc);
    n_cmp++;
    if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mwr_busy: busy=%b ready=%b want 1 0",
               busy, cmd_ready);
    end
    tick();
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mwr_ready2: ready=%b want 1", cmd_ready);
    end
    repeat (3) tick();
    n_cmp++;
    if (n_mw - b != 1 || mw_c != acc) begin
      n_fail++;
      $display("FAIL mwr_count: n=%0d at %0d want 1 at %0d",
               n_mw - b, mw_c, acc);
    end
    n_cmp++;
    if (mw_a !== 32'h10000 || mw_d !== 32'h214C62A4 ||
        mw_be !== 4'hF) begin
      n_fail++;
      $display("FAIL mwr_vals: a=%h d=%h be=%b want 10000 214c62a4 1111",
               mw_a, mw_d, mw_be);
    end
    n_cmp++;
    if (m_address !== 17'h10000 || m_writedata !== 32'h214C62A4) begin
      n_fail++;
      $display("FAIL mwr_hold: a=%h d=%h not held",
               m_address, m_writedata);
    end
    exp_mem[32'h10000] = 32'h214C62A4;
  endtask

  task automatic test_mem_read();
    int acc, br, bm;
    logic [AW-1:0] adr [12];
    logic [AW-1:0] a;
    logic [W-1:0] d;
    send(2'b00, 17'd5, 32'd2, 1'b0, acc);
    exp_mem[5] = 32'd2;
    br = n_rsp; bm = n_mr;
    send(2'b01, 17'd5, 32'd0, 1'b0, acc);
    wait_rsp(br, 40);
    repeat (4) tick();
    n_cmp++;
    if (rsp_d !== 32'd2 || rsp_c != acc + 3) begin
      n_fail++;
      $display("FAIL mrd5: data=%h at %0d want 2 at %0d",
               rsp_d, rsp_c, acc + 3);
    end
    n_cmp++;
    if (n_rsp - br != 1 || n_mr - bm != 1) begin
      n_fail++;
      $display("FAIL mrd5_count: rsp=%0d rd=%0d want 1 1",
               n_rsp - br, n_mr - bm);
    end
    for (int i = 0; i < 12; i++) begin
      a = AW'($urandom_range(0, (1 << AW) - 1));
      d = $urandom;
      adr[i] = a;
      exp_mem[int'(a)] = d;
      send(2'b00, a, d, 1'b0, acc);
    end
    for (int i = 0; i < 12; i++) begin
      a = adr[$urandom_range(0, 11)];
      br = n_rsp;
      send(2'b01, a, 32'(i), 1'b0, acc);
      wait_rsp(br, 40);
      n_cmp++;
      if (rsp_d !== exp_mem[int'(a)] || rsp_c != acc + 3) begin
        n_fail++;
        $display("FAIL mrd_rand: a=%h got %h at %0d want %h at %0d",
                 a, rsp_d, rsp_c, exp_mem[int'(a)], acc + 3);
      end
    end
  endtask

  task automatic test_back_to_back();
    int acc, bq, t = 0;
    logic [AW-1:0] a [4];
    for (int i = 0; i < 4; i++) begin
      a[i] = AW'($urandom_range(0, (1 << AW) - 1));
      exp_mem[int'(a[i])] = $urandom;
      send(2'b00, a[i], exp_mem[int'(a[i])], 1'b1, acc);
    end
    bq = rsp_q.size();
    for (int i = 0; i < 4; i++)
      send(2'b01, a[3-i], 32'hDEAD, i != 3, acc);
    while (rsp_q.size() < bq + 4 && t < 100) begin
      tick(); t++;
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (rsp_q.size() < bq + 4) begin
        n_fail++;
        $display("FAIL b2b_missing: rsp %0d of 4 absent", i);
      end else if (rsp_q[bq+i] !== exp_mem[int'(a[3-i])]) begin
        n_fail++;
        $display("FAIL b2b_data: rsp %0d got %h want %h", i,
                 rsp_q[bq+i], exp_mem[int'(a[3-i])]);
      end
    end
  endtask

  task automatic test_ctrl_finish();
    int acc, bc, bw, br, np, p, bad = 0;
    logic [2:0] ca [5] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
    logic [31:0] cd [5] = '{1, 1, 1, 0, 1};
    bw = n_cw;
    for (int i = 0; i < 5; i++)
      send(2'b10, {14'h3FFF, ca[i]}, cd[i], 1'b0, acc);
    repeat (3) tick();
    n_cmp++;
    if (n_cw - bw != 5 || ctl[2] !== 1 || ctl[3] !== 1 ||
        ctl[4] !== 1 || ctl[5] !== 0 || ctl[0] !== 1) begin
      n_fail++;
      $display("FAIL ctrl_wr: n=%0d r2..5,0=%0h %0h %0h %0h %0h",
               n_cw - bw, ctl[2], ctl[3], ctl[4], ctl[5], ctl[0]);
    end
    bc = cr_q.size(); bw = n_cw; br = n_rsp;
    fin_at = cyc + 100;
    send(2'b11, '0, '0, 1'b0, acc);
    wait_rsp(br, 400);
    np = cr_q.size() - bc;
    n_cmp++;
    if (np < 2 || cr_q[bc] != acc) begin
      n_fail++;
      $display("FAIL poll_first: polls=%0d first=%0d want >=2 at %0d",
               np, np > 0 ? cr_q[bc] : -1, acc);
    end
    for (int i = bc + 1; i < cr_q.size(); i++)
      if (cr_q[i] - cr_q[i-1] != PG + RL + 1) bad++;
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL poll_gap: %0d gaps differ from %0d",
               bad, PG + RL + 1);
    end
    p = (np > 0) ? cr_q[cr_q.size()-1] : 0;
    n_cmp++;
    if (np < 2 || p < fin_at || cr_q[cr_q.size()-2] >= fin_at) begin
      n_fail++;
      $display("FAIL poll_last: last=%0d want first poll >= %0d",
               p, fin_at);
    end
    n_cmp++;
    if (n_cw - bw != 1 || cw_a !== 1 || cw_d !== 0 ||
        cw_c != p + RL + 1) begin
      n_fail++;
      $display("FAIL clear: n=%0d a=%0h d=%0h at %0d want 1 1 0 at %0d",
               n_cw - bw, cw_a, cw_d, cw_c, p + RL + 1);
    end
    n_cmp++;
    if (rsp_d !== 32'hA5A50001 || rsp_c != cw_c + 1) begin
      n_fail++;
      $display("FAIL fin_rsp: %h at %0d want a5a50001 at %0d",
               rsp_d, rsp_c, cw_c + 1);
    end
    fin_at = NEVER;
  endtask

  task automatic test_timeout();
    int acc, bc, bw, br;
    fin_at = NEVER;
    bc = cr_q.size(); bw = n_cw; br = n_rsp;
    send(2'b11, '0, '0, 1'b0, acc);
`ifdef LOADER_TIMEOUT_EN
    wait_rsp(br, (TMO + 1) * (PG + RL + 1) + 100);
    n_cmp++;
    if (rsp_d !== 32'hFFFFFFFF || error !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_rsp: data=%h err=%b want ffffffff 1",
               rsp_d, error);
    end
    n_cmp++;
    if (cr_q.size() - bc != TMO + 1 || n_cw != bw ||
        busy !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_polls: polls=%0d cw=%0d busy=%b want %0d 0 0",
               cr_q.size() - bc, n_cw - bw, busy, TMO + 1);
    end
`else
    repeat (1000) tick();
    n_cmp++;
    if (n_rsp != br || error !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL no_tmo: rsp=%0d err=%b busy=%b want 0 0 1",
               n_rsp - br, error, busy);
    end
    n_cmp++;
    if (cr_q.size() - bc < 100) begin
      n_fail++;
      $display("FAIL no_tmo_polls: %0d polls want >=100",
               cr_q.size() - bc);
    end
`endif
  endtask

  task automatic test_reset_gap();
    int acc, bc, br, bs, t = 0;
    logic [AW-1:0] a;
    logic [W-1:0] d;
    fin_at = NEVER;
    if (!busy) send(2'b11, '0, '0, 1'b0, acc);
    bc = cr_q.size();
    while (cr_q.size() <= bc && t < 50) begin tick(); t++; end
    n_cmp++;
    if (cr_q.size() <= bc) begin
      n_fail++;
      $display("FAIL gap_poll_bound: no c_read in 50 cycles");
    end
    repeat (RL + 2) tick();
    n_cmp++;
    if (busy !== 1'b1 || c_read !== 1'b0 || c_write !== 1'b0) begin
      n_fail++;
      $display("FAIL gap_state: busy=%b cr=%b cw=%b want 1 0 0",
               busy, c_read, c_write);
    end
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({m_write, m_read, c_write, c_read,
         busy, rsp_valid} !== 6'b0) begin
      n_fail++;
      $display("FAIL gap_reset: strobes/busy/rsp=%b want 000000",
               {m_write, m_read, c_write, c_read, busy, rsp_valid});
    end
    rst = 1'b0;
    br = n_rsp;
    bs = n_mw + n_mr + n_cw + cr_q.size();
    repeat (20) tick();
    n_cmp++;
    if (n_rsp != br || n_mw + n_mr + n_cw + cr_q.size() != bs ||
        error !== 1'b0) begin
      n_fail++;
      $display("FAIL gap_quiet: rsp=%0d strobes=%0d err=%b want 0 0 0",
               n_rsp - br, n_mw + n_mr + n_cw + cr_q.size() - bs,
               error);
    end
    a = AW'($urandom_range(0, (1 << AW) - 1));
    d = $urandom;
    send(2'b00, a, d, 1'b0, acc);
    br = n_rsp;
    send(2'b01, a, '0, 1'b0, acc);
    wait_rsp(br, 40);
    n_cmp++;
    if (rsp_d !== d || rsp_c != acc + 3) begin
      n_fail++;
      $display("FAIL gap_after: got %h at %0d want %h at %0d",
               rsp_d, rsp_c, d, acc + 3);
    end
  endtask

  initial begin
    test_reset();
    test_mem_write_boundary();
    test_mem_read();
    test_back_to_back();
    test_ctrl_finish();
    test_timeout();
    test_reset_gap();
    n_cmp++;
    if (n_multi != 0 || n_badcr != 0) begin
      n_fail++;
      $display("FAIL strobe_rules: multi=%0d bad_caddr=%0d want 0 0",
               n_multi, n_badcr);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end
endmodule
